// File: rtl/bsg_fifo_1r1w_bypass.sv
// bsg_fifo_1r1w_bypass
// Bypassing FIFO with valid/ready on the input and valid/yumi on the output.
// An empty buffer forwards data_i to data_o in the same cycle. A stalled
// consumer causes items to be captured in a circular buffer of els_p entries,
// which then drain in strict arrival order.
//
// Handshake semantics:
//   input side : an item is transferred on any cycle with v_i & ready_o.
//                ready_o depends only on registered occupancy and reset_i.
//   output side: the consumer takes data_o on any cycle with v_o & yumi_i.
//                yumi_i may only be asserted while v_o is high, and it has
//                no combinational path to any output.
module bsg_fifo_1r1w_bypass #(
    parameter int width_p = 32,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,

    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,

    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    // Pointers are at least one bit wide so els_p = 1 still elaborates.
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);
    localparam logic [cnt_w_lp-1:0] els_cnt_lp  = cnt_w_lp'(els_p);

    // Storage is never reset; occupancy alone decides which entries are live.
    logic [width_p-1:0]  mem_q [els_p];

    logic [ptr_w_lp-1:0] rptr_q,  rptr_d;
    logic [ptr_w_lp-1:0] wptr_q,  wptr_d;
    logic [cnt_w_lp-1:0] count_q, count_d;

    logic empty;
    logic full;
    logic enq;
    logic deq;

    // Circular advance: the last index wraps to 0; with one entry it stays 0.
    function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
        if (p == last_ptr_lp) begin
            return '0;
        end else begin
            return p + ptr_w_lp'(1);
        end
    endfunction

    // Output side: occupancy flags, handshake outputs and the bypass mux.
    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == els_cnt_lp);
        ready_o = ~full & ~reset_i;
        v_o     = (v_i | ~empty) & ~reset_i;
        data_o  = empty ? data_i : mem_q[rptr_q];
    end

    // Transfer decisions. An empty buffer whose item is taken immediately
    // is a pure bypass and touches no state; a dequeue needs stored data.
    always_comb begin
        enq = v_i & ~full & ~(empty & yumi_i) & ~reset_i;
        deq = yumi_i & ~empty & ~reset_i;
    end

    // Next-state for pointers and occupancy.
    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;

        if (enq) begin
            wptr_d = next_ptr(wptr_q);
        end
        if (deq) begin
            rptr_d = next_ptr(rptr_q);
        end

        case ({enq, deq})
            2'b10:   count_d = count_q + cnt_w_lp'(1);
            2'b01:   count_d = count_q - cnt_w_lp'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards every stored entry.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Storage write; enq is already suppressed during reset.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wptr_q] <= data_i;
        end
    end

`ifndef SYNTHESIS
    // Protocol checks: consumer must not take absent data; occupancy bounded.
    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && !v_o))
                else $error("bsg_fifo_1r1w_bypass: yumi_i asserted while v_o low");
            assert (count_q <= els_cnt_lp)
                else $error("bsg_fifo_1r1w_bypass: count exceeds els_p");
        end
    end
`endif

endmodule

// File: tb/tb_bsg_fifo_1r1w_bypass.sv
// Testbench for bsg_fifo_1r1w_bypass: directed scenarios followed by random
// traffic, checked by a scoreboard whose expected queue is the ordered list
// of accepted-but-not-yet-consumed items.
module tb_bsg_fifo_1r1w_bypass;

    localparam int W   = 32;
    localparam int ELS = 4;

    // ---------------- clock / reset ----------------
    logic         clk_i   = 1'b0;
    logic         reset_i = 1'b1;
    logic         v_i     = 1'b0;
    logic [W-1:0] data_i  = '0;
    logic         yumi_i  = 1'b0;
    logic         ready_o;
    logic         v_o;
    logic [W-1:0] data_o;

    always #5 clk_i = ~clk_i;

    bsg_fifo_1r1w_bypass #(
        .width_p (W),
        .els_p   (ELS)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (v_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .v_o     (v_o),
        .data_o  (data_o),
        .yumi_i  (yumi_i)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic         exp_ready = 1'b0;
    logic         exp_v     = 1'b0;
    int           chk_cnt   = 0;
    int           pass_cnt  = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // One cycle of stimulus. The reference model: the buffer holds an ordered
    // list of at most ELS items; it accepts whenever it has room, presents its
    // oldest item (or the incoming one when empty), and releases it on yumi.
    task automatic drive(input logic rst, input logic v, input logic [W-1:0] d, input logic y);
        logic y_legal;
        @(posedge clk_i);
        #1;
        y_legal   = y && !rst && (v || exp_q.size() > 0);
        exp_ready = !rst && (exp_q.size() < ELS);
        exp_v     = !rst && (v || exp_q.size() > 0);
        reset_i   = rst;
        v_i       = v;
        data_i    = d;
        yumi_i    = y_legal;
        if (rst) begin
            exp_q.delete();
        end else if (v && exp_ready) begin
            exp_q.push_back(d);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk_i) begin
        check("ready_o", W'(ready_o), W'(exp_ready));
        check("v_o", W'(v_o), W'(exp_v));
        if (exp_v) begin
            if (exp_q.size() == 0) begin
                check("model_head_present", 32'd0, 32'd1);
            end else begin
                check("data_o", data_o, exp_q[0]);
            end
        end
        if (!reset_i && yumi_i && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset held two cycles with the producer already valid.
        drive(1'b1, 1'b1, 32'hDEAD_0000, 1'b0);
        drive(1'b1, 1'b1, 32'hDEAD_0001, 1'b0);

        // Zero-latency bypass right after reset.
        drive(1'b0, 1'b1, 32'hA5A5_0001, 1'b1);

        // Fill to full under stall, then a rejected 5th item.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 32'h10 + i, 1'b0);
        drive(1'b0, 1'b1, 32'h14, 1'b0);

        // Drain in order, then idle.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, '0, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b0);

        // Hold two entries while streaming; pointers wrap repeatedly.
        drive(1'b0, 1'b1, 32'h20, 1'b0);
        drive(1'b0, 1'b1, 32'h21, 1'b0);
        for (int i = 2; i < 16; i++) drive(1'b0, 1'b1, 32'h20 + i, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b0);

        // Full with simultaneous yumi: head leaves, 0x30 is not taken.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 32'h50 + i, 1'b0);
        drive(1'b0, 1'b1, 32'h30, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, '0, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b0);

        // Reset mid-burst discards stored data; next item bypasses.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 32'h60 + i, 1'b0);
        drive(1'b1, 1'b0, '0, 1'b0);
        drive(1'b0, 1'b1, 32'h40, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 63) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom,
                  $urandom_range(0, 2) != 0);
        end
        drive(1'b0, 1'b0, '0, 1'b0);

        @(negedge clk_i);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
